// File: rtl/sseg_mux_driver.sv
// Time-multiplexed scan driver for an N-digit seven-segment display with
// inter-digit blanking, per-digit enable, PWM brightness and frame snapshots.
module sseg_mux_driver #(
  parameter  int N_DIGITS     = 4,
  parameter  int TICK_DIV     = 50000,
  parameter  int BLANK_CYCLES = 2000,
  localparam int DW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_sseg_n [N_DIGITS-1:0],
  input  logic [N_DIGITS-1:0] i_dig_en,
  input  logic [3:0]          i_bright,
  output logic [N_DIGITS-1:0] o_an_n,
  output logic [7:0]          o_sseg_n,
  output logic [DW-1:0]       o_digit,
  output logic                o_frame_tick
);

  localparam int             CW         = $clog2(TICK_DIV);
  localparam int             STEP       = (TICK_DIV - BLANK_CYCLES) / 16;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0]  DIG_LAST   = DW'(N_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [7:0]            snap_q [N_DIGITS-1:0];
  logic [7:0]            snap_d [N_DIGITS-1:0];
  logic                  en_q, en_d;
  logic [3:0]            bright_q, bright_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic                  frame_q, frame_d;
  logic                  slot_start;
  logic                  slot_wrap;
  logic                  lit;

  // PWM window: the first (bright+1)/16 of the post-blank region is lit.
  function automatic logic in_window(input logic [CW-1:0] cnt,
                                     input logic [3:0]    br);
    int off;
    int lim;
    off = int'(cnt) - BLANK_CYCLES;
    lim = (int'(br) + 1) * STEP;
    return (off >= 0) && (off < lim);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      dig_q    <= '0;
      snap_q   <= '{default: 8'hFF};
      en_q     <= 1'b0;
      bright_q <= 4'd0;
      an_q     <= '1;
      sseg_q   <= 8'hFF;
      digit_q  <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      snap_q   <= snap_d;
      en_q     <= en_d;
      bright_q <= bright_d;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    snap_d     = snap_q;
    en_d       = en_q;
    bright_d   = bright_q;
    an_d       = '1;
    sseg_d     = 8'hFF;
    digit_d    = dig_q;
    frame_d    = 1'b0;
    slot_start = (cnt_q == '0);
    slot_wrap  = (cnt_q == CNT_LAST);
    lit        = 1'b0;

    if (slot_wrap) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_ON;
      ST_ON:    if (slot_wrap)           state_d = ST_BLANK;
      default:                           state_d = ST_BLANK;
    endcase

    // Patterns are captured once per frame so a frame never mixes old and new data.
    if (slot_start) begin
      en_d     = i_dig_en[dig_q];
      bright_d = i_bright;
      if (dig_q == '0) snap_d = i_sseg_n;
      frame_d  = (dig_q == '0);
    end

    lit = (state_q == ST_ON) && en_q && in_window(cnt_q, bright_q);
    if (lit) begin
      an_d[dig_q] = 1'b0;
      sseg_d      = snap_q[dig_q];
    end
  end

  assign o_an_n       = an_q;
  assign o_sseg_n     = sseg_q;
  assign o_digit      = digit_q;
  assign o_frame_tick = frame_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver: cycle-accurate behavioural model from absolute
// slot/frame arithmetic, directed literal checks, and a randomized soak.
module tb_sseg_mux_driver;

  localparam int N    = 4;
  localparam int TD   = 20;
  localparam int BC   = 4;
  localparam int STEP = (TD - BC) / 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   sseg [N-1:0];
  logic [N-1:0] en;
  logic [3:0]   br;
  logic [N-1:0] an_n;
  logic [7:0]   seg_n;
  logic [1:0]   dig;
  logic         ft;

  int n_cmp = 0;
  int n_bad = 0;
  int ns    = 0;

  sseg_mux_driver #(.N_DIGITS(N), .TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sseg_n     (sseg),
    .i_dig_en     (en),
    .i_bright     (br),
    .o_an_n       (an_n),
    .o_sseg_n     (seg_n),
    .o_digit      (dig),
    .o_frame_tick (ft)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: outputs in cycle m+1 follow from slot = m / TD,
  // position c = m % TD and the values latched at the slot/frame start.
  bit           m_valid = 0;
  int           mn, mc, md;
  logic [7:0]   m_snap [N-1:0];
  logic         m_en;
  logic [3:0]   m_br;
  logic         m_lit;
  logic [N-1:0] one_hot;
  logic [N-1:0] e_an;
  logic [7:0]   e_seg;
  logic [1:0]   e_dig;
  logic         e_ft;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("an_n",   32'(an_n),  32'(e_an));
      chk("sseg_n", 32'(seg_n), 32'(e_seg));
      chk("digit",  32'(dig),   32'(e_dig));
      chk("frame",  32'(ft),    32'(e_ft));
      chk("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
      chk("dark_seg",  32'((an_n == '1) ? seg_n : 8'hFF), 32'hFF);
    end
    if (rst) begin
      m_valid = 1;
      mn      = 0;
      for (int i = 0; i < N; i++) m_snap[i] = 8'hFF;
      m_en    = 1'b0;
      m_br    = 4'd0;
      e_an    = '1;
      e_seg   = 8'hFF;
      e_dig   = 2'd0;
      e_ft    = 1'b0;
    end else if (m_valid) begin
      mc = mn % TD;
      md = (mn / TD) % N;
      if (mc == 0) begin
        m_en = en[md];
        m_br = br;
        if (md == 0) m_snap = sseg;
      end
      m_lit   = (mc >= BC) && m_en && ((mc - BC) < (int'(m_br) + 1) * STEP);
      one_hot = N'(1) << md;
      e_an    = m_lit ? ~one_hot : '1;
      e_seg   = m_lit ? m_snap[md] : 8'hFF;
      e_dig   = 2'(md);
      e_ft    = (mc == 0) && (md == 0);
      mn++;
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
    ns += k;
  endtask

  task automatic count_lit(input int k, output int total, output int masked);
    total  = 0;
    masked = 0;
    for (int i = 0; i < k; i++) begin
      step(1);
      if (an_n != '1) total++;
      if (an_n == 4'b1110 || an_n == 4'b1011) masked++;
    end
  endtask

  int tot, msk;

  initial begin
    sseg[3] = 8'hA1; sseg[2] = 8'hB2; sseg[1] = 8'hC3; sseg[0] = 8'hD4;
    en  = 4'hF;
    br  = 4'd15;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    ns = 0;

    // Full brightness, all digits enabled
    chk("rst_an",   32'(an_n),  32'hF);
    chk("rst_seg",  32'(seg_n), 32'hFF);
    chk("rst_dig",  32'(dig),   32'd0);
    chk("rst_ft",   32'(ft),    32'd0);
    step(1);  chk("c1_an", 32'(an_n), 32'hF); chk("c1_ft", 32'(ft), 32'd1);
    step(3);  chk("c4_an", 32'(an_n), 32'hF);
    step(1);  chk("c5_an", 32'(an_n), 32'hE); chk("c5_seg", 32'(seg_n), 32'hD4);
    step(15); chk("c20_an", 32'(an_n), 32'hE);
    step(1);  chk("c21_an", 32'(an_n), 32'hF); chk("c21_dig", 32'(dig), 32'd1);
    step(4);  chk("c25_an", 32'(an_n), 32'hD); chk("c25_seg", 32'(seg_n), 32'hC3);

    // Pattern change mid-frame must wait for the next frame
    sseg[3] = 8'h9C;
    step(40); chk("c65_an", 32'(an_n), 32'h7); chk("c65_seg", 32'(seg_n), 32'hA1);
    step(16); chk("c81_ft", 32'(ft), 32'd1);   chk("c81_an", 32'(an_n), 32'hF);
    step(64); chk("c145_an", 32'(an_n), 32'h7); chk("c145_seg", 32'(seg_n), 32'h9C);

    // Brightness 3 and 0: lit cycles per 80-cycle frame
    br = 4'd3;
    step(40);
    count_lit(80, tot, msk); chk("lit_b3", 32'(tot), 32'd16);
    br = 4'd0;
    step(40);
    count_lit(80, tot, msk); chk("lit_b0", 32'(tot), 32'd4);

    // Digits 0 and 2 masked
    br = 4'd15;
    en = 4'b1010;
    step(40);
    count_lit(80, tot, msk);
    chk("lit_mask", 32'(tot), 32'd32);
    chk("masked_sel", 32'(msk), 32'd0);

    // Reset in the middle of the digit-2 ON window
    en = 4'hF;
    step(40);
    step((50 - (ns % 80) + 80) % 80);
    chk("d2_an", 32'(an_n), 32'hB); chk("d2_seg", 32'(seg_n), 32'hB2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    ns = 0;
    chk("mid_rst_an",  32'(an_n),  32'hF);
    chk("mid_rst_seg", 32'(seg_n), 32'hFF);
    chk("mid_rst_dig", 32'(dig),   32'd0);
    step(4); chk("r4_an", 32'(an_n), 32'hF);
    step(1); chk("r5_an", 32'(an_n), 32'hE); chk("r5_seg", 32'(seg_n), 32'hD4);

    // Randomized soak, occasional single-cycle resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) br = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sseg[$urandom_range(0, N - 1)] = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
